// File: rtl/d7_pkg.sv
// rtl/d7_pkg.sv - shared constants and one-hot helpers for the muxpb decoder
package d7_pkg;

  localparam int N_DIGITS        = 8;
  localparam int IDX_W           = $clog2(N_DIGITS);
  localparam int DEB_SCANS       = 4;
  localparam int DEB_SCANS_TURBO = 1;
  localparam int MIN_SLOT        = 3;
  localparam int STALL_CYCLES    = 1024;
  localparam int CNT_W           = $clog2(DEB_SCANS + 1);
  localparam int SLOT_W          = $clog2(STALL_CYCLES + 1);

  typedef logic [N_DIGITS-1:0] anode_t;
  typedef logic [IDX_W-1:0]    idx_t;
  typedef logic [CNT_W-1:0]    deb_cnt_t;
  typedef logic [SLOT_W-1:0]   slot_cnt_t;

  localparam deb_cnt_t  DEB_T_NORMAL = deb_cnt_t'(DEB_SCANS);
  localparam deb_cnt_t  DEB_T_TURBO  = deb_cnt_t'(DEB_SCANS_TURBO);
  localparam slot_cnt_t SLOT_SAT     = slot_cnt_t'(STALL_CYCLES);

  function automatic logic is_onehot(input anode_t v);
    return (v != '0) && ((v & (v - anode_t'(1))) == '0);
  endfunction

  // OR of set-bit indices; exact only when v is one-hot, 0 when v is zero
  function automatic idx_t onehot_index(input anode_t v);
    idx_t idx;
    idx = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (v[i]) idx = idx | idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pb_debounce_cell.sv
// rtl/pb_debounce_cell.sv - per-position scan-count debouncer with edge pulses
module pb_debounce_cell
  import d7_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     sample_en_i,
  input  logic     sample_i,
  input  deb_cnt_t thresh_i,
  output logic     level_o,
  output logic     press_o,
  output logic     release_o,
  output logic     press_next_o
);

  deb_cnt_t cnt_q, cnt_d;
  logic     level_q, level_d;
  logic     press_q, press_d;
  logic     release_q, release_d;

  // A counter left above a newly lowered threshold toggles on its next disagreeing sample
  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sample_en_i) begin
      if (sample_i == level_q) begin
        cnt_d = '0;
      end else if ((cnt_q + deb_cnt_t'(1)) >= thresh_i) begin
        cnt_d     = '0;
        level_d   = ~level_q;
        press_d   = ~level_q;
        release_d = level_q;
      end else begin
        cnt_d = cnt_q + deb_cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o      = level_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign press_next_o = press_d;

endmodule

// File: rtl/d7_muxpb_decoder.sv
// rtl/d7_muxpb_decoder.sv - samples muxpb per anode slot and debounces each button position
module d7_muxpb_decoder
  import d7_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                turbosim,
  input  logic [N_DIGITS-1:0] d7_anodes,
  input  logic                muxpb,
  output logic [N_DIGITS-1:0] pb_state,
  output logic [N_DIGITS-1:0] pb_press,
  output logic [N_DIGITS-1:0] pb_release,
  output logic                key_valid,
  output logic [IDX_W-1:0]    key_index,
  output logic                scan_error,
  output logic                scan_stall
);

  logic      sync1_q, sync2_q;
  anode_t    anode_q;
  slot_cnt_t slot_cnt_q, slot_cnt_d;
  logic      stall_q, stall_d;
  logic      slot_open_q, slot_open_d;
  logic      scan_err_q, scan_err_d;
  logic      key_valid_q, key_valid_d;
  idx_t      key_index_q, key_index_d;

  logic      anode_change, slot_end, anode_ok, slot_long, sample_valid;
  anode_t    sample_en, press_next;
  deb_cnt_t  thresh;

  // The anode_q left by reset is not a real slot, so the first change only opens slot tracking
  always_comb begin
    anode_change = (d7_anodes != anode_q);
    slot_end     = anode_change && slot_open_q;
    anode_ok     = is_onehot(anode_q);
    slot_long    = (int'(slot_cnt_q) + 1) >= MIN_SLOT;
    sample_valid = slot_end && anode_ok && slot_long && !stall_q;
    sample_en    = sample_valid ? anode_q : '0;
    slot_open_d  = slot_open_q || anode_change;
    scan_err_d   = slot_end && !anode_ok;
    thresh       = turbosim ? DEB_T_TURBO : DEB_T_NORMAL;

    slot_cnt_d = slot_cnt_q;
    if (anode_change) begin
      slot_cnt_d = '0;
    end else if (slot_cnt_q != SLOT_SAT) begin
      slot_cnt_d = slot_cnt_q + slot_cnt_t'(1);
    end
    stall_d = !anode_change && (slot_cnt_d == SLOT_SAT);

    key_valid_d = |press_next;
    key_index_d = onehot_index(press_next);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      anode_q     <= '0;
      slot_cnt_q  <= '0;
      stall_q     <= 1'b0;
      slot_open_q <= 1'b0;
      scan_err_q  <= 1'b0;
      key_valid_q <= 1'b0;
      key_index_q <= '0;
    end else begin
      sync1_q     <= muxpb;
      sync2_q     <= sync1_q;
      anode_q     <= d7_anodes;
      slot_cnt_q  <= slot_cnt_d;
      stall_q     <= stall_d;
      slot_open_q <= slot_open_d;
      scan_err_q  <= scan_err_d;
      key_valid_q <= key_valid_d;
      key_index_q <= key_index_d;
    end
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_cell
    pb_debounce_cell u_cell (
      .clk          (clk),
      .reset        (reset),
      .sample_en_i  (sample_en[g]),
      .sample_i     (sync2_q),
      .thresh_i     (thresh),
      .level_o      (pb_state[g]),
      .press_o      (pb_press[g]),
      .release_o    (pb_release[g]),
      .press_next_o (press_next[g])
    );
  end

  assign key_valid  = key_valid_q;
  assign key_index  = key_index_q;
  assign scan_error = scan_err_q;
  assign scan_stall = stall_q;

endmodule

// File: tb/tb_d7_muxpb_decoder.sv
// tb/tb_d7_muxpb_decoder.sv - directed self-checking bench for d7_muxpb_decoder
module tb_d7_muxpb_decoder;

  logic       clk;
  logic       reset;
  logic       turbosim;
  logic [7:0] d7_anodes;
  logic       muxpb;
  logic [7:0] pb_state, pb_press, pb_release;
  logic       key_valid;
  logic [2:0] key_index;
  logic       scan_error, scan_stall;

  logic [7:0] press_mask;
  int         n_checks, n_errors;
  int         press_cnt[8];
  int         release_cnt[8];
  int         n_key, err_cnt;
  logic [2:0] last_key;
  int         snap;

  d7_muxpb_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .turbosim   (turbosim),
    .d7_anodes  (d7_anodes),
    .muxpb      (muxpb),
    .pb_state   (pb_state),
    .pb_press   (pb_press),
    .pb_release (pb_release),
    .key_valid  (key_valid),
    .key_index  (key_index),
    .scan_error (scan_error),
    .scan_stall (scan_stall)
  );

  // Pressed buttons short their anode line onto the return line
  assign muxpb = |(d7_anodes & press_mask);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic slot(input logic [7:0] an, input int len);
    d7_anodes = an;
    repeat (len) @(negedge clk);
  endtask

  task automatic rotate(input int n);
    for (int r = 0; r < n; r++)
      for (int k = 0; k < 8; k++)
        slot(8'(1 << k), 4);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        if (pb_press[i])   press_cnt[i]++;
        if (pb_release[i]) release_cnt[i]++;
      end
      if (scan_error) err_cnt++;
      if (key_valid || (pb_press != 8'h00))
        check("key_valid_with_press", {31'd0, key_valid}, {31'd0, |pb_press});
      if (key_valid) begin
        n_key++;
        last_key = key_index;
      end
    end
  end

  initial begin
    n_checks = 0; n_errors = 0; n_key = 0; err_cnt = 0; last_key = 3'd0;
    for (int i = 0; i < 8; i++) begin press_cnt[i] = 0; release_cnt[i] = 0; end
    reset = 1'b0; turbosim = 1'b0; d7_anodes = 8'h00; press_mask = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_pb_state", pb_state, 0);
    check("rst_pb_press", pb_press, 0);
    check("rst_pb_release", pb_release, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_index", key_index, 0);
    check("rst_scan_error", scan_error, 0);
    check("rst_scan_stall", scan_stall, 0);

    // idle scan, nothing pressed
    reset = 1'b1;
    rotate(2);
    check("idle_pb_state", pb_state, 0);
    check("idle_press", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[7], 0);
    check("idle_scan_error", err_cnt, 0);

    // normal debounce on position 2
    press_mask = 8'h04;
    rotate(3);
    check("p2_after3_state", pb_state, 8'h00);
    check("p2_after3_press", press_cnt[2], 0);
    rotate(1);
    check("p2_after4_state", pb_state, 8'h04);
    check("p2_press_cnt", press_cnt[2], 1);
    check("p2_key_cnt", n_key, 1);
    check("p2_key_index", last_key, 2);
    press_mask = 8'h00;
    rotate(3);
    check("p2_rel3_state", pb_state, 8'h04);
    rotate(1);
    check("p2_rel4_state", pb_state, 8'h00);
    check("p2_release_cnt", release_cnt[2], 1);

    // turbo: one scan is enough
    turbosim = 1'b1;
    press_mask = 8'h20;
    rotate(1);
    check("t5_state", pb_state, 8'h20);
    check("t5_press_cnt", press_cnt[5], 1);
    check("t5_key_index", last_key, 5);
    press_mask = 8'h00;
    rotate(1);
    check("t5_rel_state", pb_state, 8'h00);
    check("t5_release_cnt", release_cnt[5], 1);

    // 3-scan glitch is rejected and the counter restarts
    turbosim = 1'b0;
    press_mask = 8'h20;
    rotate(3);
    press_mask = 8'h00;
    rotate(1);
    check("glitch_state", pb_state, 8'h00);
    check("glitch_press_cnt", press_cnt[5], 1);
    press_mask = 8'h20;
    rotate(3);
    check("glitch_cleared_state", pb_state, 8'h00);
    rotate(1);
    check("glitch_then_press", pb_state, 8'h20);
    check("glitch_press_cnt2", press_cnt[5], 2);
    press_mask = 8'h00;
    rotate(4);
    check("glitch_release", pb_state, 8'h00);

    // minimum slot length: 2 clocks discarded, 3 clocks accepted
    turbosim = 1'b1;
    press_mask = 8'h01;
    slot(8'h01, 2);
    slot(8'h02, 4);
    check("short_slot_state", pb_state, 8'h00);
    slot(8'h01, 3);
    slot(8'h02, 4);
    check("min_slot_state", pb_state, 8'h01);
    check("min_slot_press", press_cnt[0], 1);
    press_mask = 8'h00;
    rotate(1);
    check("min_slot_release", pb_state, 8'h00);

    // bad slots: zero and multi-hot anodes
    snap = err_cnt;
    press_mask = 8'h11;
    slot(8'h00, 4);
    slot(8'h11, 4);
    press_mask = 8'h00;
    rotate(1);
    check("bad_slot_errors", err_cnt - snap, 2);
    check("bad_slot_state", pb_state, 8'h00);

    // stall on a held anode, resume slot is not sampled
    press_mask = 8'h08;
    slot(8'h08, 1024);
    check("stall_before", scan_stall, 0);
    slot(8'h08, 1);
    check("stall_set", scan_stall, 1);
    slot(8'h08, 1100 - 1025);
    check("stall_held", scan_stall, 1);
    press_mask = 8'h00;
    slot(8'h10, 1);
    check("stall_cleared", scan_stall, 0);
    slot(8'h10, 3);
    check("stall_no_press_state", pb_state, 8'h00);
    check("stall_no_press_cnt", press_cnt[3], 0);

    // async reset in the middle of a debounce
    press_mask = 8'h01;
    rotate(1);
    check("pre_rst_state", pb_state, 8'h01);
    turbosim = 1'b0;
    press_mask = 8'h05;
    rotate(3);
    check("mid_deb_state", pb_state, 8'h01);
    snap = press_cnt[2];
    #2 reset = 1'b0;
    #1;
    check("async_rst_state", pb_state, 8'h00);
    check("async_rst_key_valid", key_valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rotate(3);
    check("post_rst3_state", pb_state, 8'h00);
    check("post_rst3_press", press_cnt[2], snap);
    rotate(1);
    check("post_rst4_state", pb_state, 8'h05);
    check("post_rst4_press", press_cnt[2], snap + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/d7_muxpb_decoder.md
Name: d7_muxpb_decoder

Overview:
- Receive side of the multiplexed pushbutton interface. Buttons are wired between individual 7-segment anode lines and the shared muxpb return line.
- The block watches the anode scan and samples muxpb once per completed anode slot. It debounces each digit position independently.
- Outputs are per-position debounced levels, press/release pulses and an encoded key event, consumed by the game FSM for digit setting.
- Sits beside the 7-segment scan driver, on the same clock.

Parameters:
- N_DIGITS, 8, number of anode lines / button positions.
- DEB_SCANS, 4, consecutive disagreeing samples required to change a debounced level.
- MIN_SLOT, 3, minimum anode slot length in clocks for its sample to be valid.
- STALL_CYCLES, 1024, clocks without an anode change before scan_stall asserts.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset.
- turbosim  in  1  1 = debounce threshold forced to 1 scan (simulation speed-up).
- d7_anodes  in  N_DIGITS  anode scan from the display driver; active-high, one-hot during a valid slot.
- muxpb  in  1  asynchronous button return line; high = button on the active anode pressed.
- pb_state  out  N_DIGITS  debounced level per position.
- pb_press  out  N_DIGITS  one-clock pulse on a debounced 0->1 transition.
- pb_release  out  N_DIGITS  one-clock pulse on a debounced 1->0 transition.
- key_valid  out  1  one-clock pulse, coincident with any pb_press bit.
- key_index  out  3  index of the pressed position; valid when key_valid=1, else 0.
- scan_error  out  1  one-clock pulse when a slot ends with non-one-hot anodes.
- scan_stall  out  1  level; anodes unchanged for STALL_CYCLES.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Port reset (0 = reset asserted). All flops clear asynchronously on reset low and release on the clk edge after reset goes high.
- Reset values: every output is 0. Internal state also clears: sync flops, anode_q, slot counter and all debounce counters.
- Synchroniser:
  - muxpb passes through a 2-FF synchroniser to give muxpb_s.
  - d7_anodes is registered once into anode_q; it is not synchronised because it comes from the same clock domain.
- Slot counter:
  - Cleared to 0 on the clock where d7_anodes != anode_q.
  - Otherwise increments, saturating at STALL_CYCLES.
- Slot end:
  - Occurs on the clock where d7_anodes != anode_q.
  - The sample is muxpb_s at that clock and is attributed to the one-hot index of anode_q.
  - The sample is valid only if anode_q is one-hot, slot count+1 >= MIN_SLOT, and scan_stall=0.
  - anode_q non-one-hot at slot end (zero or multi-hot): no sample, scan_error pulses for 1 clock.
  - Too-short slot: sample discarded silently.
- Debounce, per position i, with threshold T = 1 if turbosim else DEB_SCANS:
  - Valid sample equal to pb_state[i]: counter i cleared.
  - Valid sample different from pb_state[i]: counter i increments.
  - When the counter reaches T, pb_state[i] toggles and the counter clears.
  - pb_press[i] or pb_release[i] pulses on the same registered edge as the pb_state[i] change.
- Only one position is updated per clock, so at most one press bit is set at a time. key_valid = |pb_press and key_index = encoded index, both registered with pb_press.
- Stall:
  - scan_stall sets when the slot counter reaches STALL_CYCLES.
  - It clears on the clock of the next anode change.
  - The slot that ends a stall is not sampled. Debounce counters and pb_state hold their values.
- Latency from muxpb edge to pb_press: 2 sync clocks, plus the wait for the slot end, plus T-1 further scans of that position.
- turbosim changes mid-operation: the new T applies at the next sample. A counter already >= the new T toggles on the next disagreeing sample.
- Reset mid-operation: all state clears immediately. No pulse is generated on reset release.

Decomposition:
- Shared package/include (d7_pkg): N_DIGITS, DEB_SCANS, DEB_SCANS_TURBO=1, and the one-hot-to-index function with its one-hot check.
- One natural sub-module: pb_debounce_cell (one counter plus level plus pulse), instantiated N_DIGITS times with a sample-enable input.
- Synchroniser and slot tracking stay in the top level.

Test Plan:
- Reset, then scan anodes 8'h01..8'h80 in a 4-clock-per-slot rotation with muxpb=0 -> all outputs stay 0 and no scan_error.
- turbosim=0; muxpb = d7_anodes[2] (tied through) -> pb_press[2], key_valid=1, key_index=2 on the 4th scan of slot 2; pb_state=8'h04. Release muxpb -> pb_release[2] after 4 scans; pb_state=8'h00.
- turbosim=1; muxpb = d7_anodes[5] for one scan only -> pb_press[5] after the first scan of slot 5. With turbosim=0, a 3-scan glitch -> no press and counter cleared.
- Insert a slot with anodes 8'h00, then one with 8'h11 -> scan_error pulses once per bad slot; pb_state unchanged.
- Hold anodes at 8'h08 for 1100 clocks with muxpb=1 -> scan_stall=1 from clock 1024. On resume, the slot is not sampled, stall clears and there is no press.
- Assert reset low mid-debounce (counter 3 of 4) -> outputs go 0 immediately; after release, 4 fresh scans are needed before the press.
